// File: rtl/result_collector.sv
// Collects one result beat per lane into holding registers, then serializes the
// complete row in lane order onto a single output stream with frame accounting.
module result_collector #(
    parameter int unsigned RSLT_WIDTH  = 16,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned KEEP_WIDTH  = (RSLT_WIDTH + 7) / 8,
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned DEST_WIDTH  = 8,
    parameter int unsigned OUTPUT_ID   = 1,
    parameter int unsigned OUTPUT_DEST = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*RSLT_WIDTH-1:0] s_axis_rslt_tdata,
    input  logic [CHANNELS-1:0]            s_axis_rslt_tvalid,
    output logic [CHANNELS-1:0]            s_axis_rslt_tready,
    input  logic [CHANNELS-1:0]            s_axis_rslt_tlast,
    output logic [RSLT_WIDTH-1:0]          m_axis_data_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_data_tkeep,
    output logic                           m_axis_data_tvalid,
    input  logic                           m_axis_data_tready,
    output logic                           m_axis_data_tlast,
    output logic [ID_WIDTH-1:0]            m_axis_data_tid,
    output logic [DEST_WIDTH-1:0]          m_axis_data_tdest,
    output logic                           err_unaligned_data,
    output logic [31:0]                    frame_count
);

    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic {StFill, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    row_last_q, row_last_d;
    logic                    err_q, err_d;
    logic [31:0]             frame_count_q, frame_count_d;
    logic                    clear_full;

    logic [RSLT_WIDTH-1:0]   lane_data_q [CHANNELS];
    logic [CHANNELS-1:0]     lane_last_q;
    logic [CHANNELS-1:0]     full_q;

    // Lane holding registers; a full lane refuses new data until the row drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            lane_last_q <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                lane_data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (clear_full) begin
                    full_q[k] <= 1'b0;
                end else if (s_axis_rslt_tvalid[k] && !full_q[k]) begin
                    full_q[k]      <= 1'b1;
                    lane_last_q[k] <= s_axis_rslt_tlast[k];
                    lane_data_q[k] <= s_axis_rslt_tdata[k*RSLT_WIDTH +: RSLT_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFill;
            idx_q         <= '0;
            row_last_q    <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_last_q    <= row_last_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_last_d    = row_last_q;
        err_d         = err_q;
        frame_count_d = frame_count_q;
        clear_full    = 1'b0;
        unique case (state_q)
            StFill: begin
                if (&full_q) begin
                    state_d    = StDrain;
                    idx_d      = '0;
                    row_last_d = &lane_last_q;
                    if ((|lane_last_q) != (&lane_last_q)) begin
                        err_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (m_axis_data_tready) begin
                    if (idx_q == LAST_IDX) begin
                        clear_full = 1'b1;
                        state_d    = StFill;
                        idx_d      = '0;
                        if (row_last_q) begin
                            frame_count_d = frame_count_q + 32'd1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Outputs come from registers only, so the beat holds under backpressure.
    always_comb begin
        m_axis_data_tvalid = (state_q == StDrain);
        m_axis_data_tdata  = m_axis_data_tvalid ? lane_data_q[idx_q] : '0;
        m_axis_data_tlast  = m_axis_data_tvalid && row_last_q && (idx_q == LAST_IDX);
    end

    assign s_axis_rslt_tready = ~full_q;
    assign m_axis_data_tkeep  = '1;
    assign m_axis_data_tid    = ID_WIDTH'(OUTPUT_ID);
    assign m_axis_data_tdest  = DEST_WIDTH'(OUTPUT_DEST);
    assign err_unaligned_data = err_q;
    assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: table of whole rows plus hand-written
// sequences for staggered arrival, backpressure and mid-drain reset.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_data = '0;
    logic [3:0]  s_valid = '0;
    logic [3:0]  s_ready;
    logic [3:0]  s_last = '0;
    logic [15:0] m_data;
    logic [1:0]  m_keep;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic [7:0]  m_id;
    logic [7:0]  m_dest;
    logic        err;
    logic [31:0] fcount;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_collector dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_rslt_tdata  (s_data),
        .s_axis_rslt_tvalid (s_valid),
        .s_axis_rslt_tready (s_ready),
        .s_axis_rslt_tlast  (s_last),
        .m_axis_data_tdata  (m_data),
        .m_axis_data_tkeep  (m_keep),
        .m_axis_data_tvalid (m_valid),
        .m_axis_data_tready (m_ready),
        .m_axis_data_tlast  (m_last),
        .m_axis_data_tid    (m_id),
        .m_axis_data_tdest  (m_dest),
        .err_unaligned_data (err),
        .frame_count        (fcount)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  last;
        logic [31:0] fc_after;
        logic        err_after;
    } row_t;

    row_t rows [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present all four lanes in one cycle and check capture-to-valid latency.
    task automatic present(input logic [63:0] d, input logic [3:0] l);
        s_data  = d;
        s_last  = l;
        s_valid = 4'hf;
        step();
        s_valid = 4'h0;
        check("capture_tready", {60'd0, s_ready}, 64'h0);
        check("fill_tvalid", {63'd0, m_valid}, 64'd0);
        step();
        check("latency_tvalid", {63'd0, m_valid}, 64'd1);
    endtask

    task automatic drain(input logic [63:0] d, input logic [3:0] l, input logic [31:0] fc_before);
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_tvalid", {63'd0, m_valid}, 64'd1);
            check("drain_tdata", {48'd0, m_data}, {48'd0, d[k*16 +: 16]});
            check("drain_tlast", {63'd0, m_last}, {63'd0, (k == 3) && (&l)});
            check("drain_fcount", {32'd0, fcount}, {32'd0, fc_before});
            step();
        end
        check("post_tready", {60'd0, s_ready}, 64'hf);
        check("post_tvalid", {63'd0, m_valid}, 64'd0);
    endtask

    initial begin
        logic [31:0] fc_model;
        logic [63:0] bp_data;
        logic        bp_pat [12];
        int          beats;

        rows[0] = '{64'h0044_0033_0022_0011, 4'b0000, 32'd0, 1'b0};
        rows[1] = '{64'h0088_0077_0066_0055, 4'b1111, 32'd1, 1'b0};
        rows[2] = '{64'h00CC_00BB_00AA_0099, 4'b1101, 32'd1, 1'b1};
        rows[3] = '{64'h1004_1003_1002_1001, 4'b0000, 32'd1, 1'b1};
        bp_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        step();
        step();
        rst = 1'b0;
        step();
        check("rst_tready", {60'd0, s_ready}, 64'hf);
        check("rst_tvalid", {63'd0, m_valid}, 64'd0);
        check("rst_tlast", {63'd0, m_last}, 64'd0);
        check("rst_tdata", {48'd0, m_data}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_fcount", {32'd0, fcount}, 64'd0);
        check("const_tkeep", {62'd0, m_keep}, 64'h3);
        check("const_tid", {56'd0, m_id}, 64'd1);
        check("const_tdest", {56'd0, m_dest}, 64'd0);

        fc_model = 32'd0;
        for (int r = 0; r < 4; r++) begin
            present(rows[r].data, rows[r].last);
            check("row_err", {63'd0, err}, {63'd0, rows[r].err_after});
            drain(rows[r].data, rows[r].last, fc_model);
            fc_model = rows[r].fc_after;
            check("row_fcount", {32'd0, fcount}, {32'd0, fc_model});
        end

        // Staggered arrival: lane 2 lags the others by five cycles.
        s_data  = 64'h0404_0303_0202_0101;
        s_last  = 4'b0000;
        s_valid = 4'b1011;
        step();
        s_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("stagger_tready", {60'd0, s_ready}, 64'b0100);
            check("stagger_tvalid", {63'd0, m_valid}, 64'd0);
            step();
        end
        s_valid = 4'b0100;
        step();
        s_valid = 4'b0000;
        check("stagger_fill", {63'd0, m_valid}, 64'd0);
        step();
        drain(64'h0404_0303_0202_0101, 4'b0000, fc_model);

        // Backpressure: beat must hold until accepted, exactly four handshakes.
        bp_data = 64'h00A4_00A3_00A2_00A1;
        present(bp_data, 4'b0000);
        beats = 0;
        for (int i = 0; i < 12 && beats < 4; i++) begin
            m_ready = bp_pat[i];
            #1;
            check("bp_tvalid", {63'd0, m_valid}, 64'd1);
            check("bp_tdata", {48'd0, m_data}, {48'd0, bp_data[beats*16 +: 16]});
            check("bp_tlast", {63'd0, m_last}, 64'd0);
            if (m_ready) beats++;
            step();
        end
        check("bp_beats", 64'(beats), 64'd4);
        check("bp_done_tvalid", {63'd0, m_valid}, 64'd0);
        check("err_sticky", {63'd0, err}, 64'd1);
        m_ready = 1'b1;

        // Reset after two drained beats discards the row.
        present(64'h00B4_00B3_00B2_00B1, 4'b1111);
        check("pre_rst_b0", {48'd0, m_data}, 64'h00B1);
        step();
        check("pre_rst_b1", {48'd0, m_data}, 64'h00B2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_tvalid", {63'd0, m_valid}, 64'd0);
        check("mrst_tready", {60'd0, s_ready}, 64'hf);
        check("mrst_fcount", {32'd0, fcount}, 64'd0);
        check("mrst_err", {63'd0, err}, 64'd0);
        present(64'h00C4_00C3_00C2_00C1, 4'b0000);
        drain(64'h00C4_00C3_00C2_00C1, 4'b0000, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
